// File: rtl/diffeq_ctrl_pkg.sv
// diffeq_ctrl_pkg: state encoding, operand indices and default widths shared by
// the differentiator sequencer.
package diffeq_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT, S_RESP} state_t;
    localparam logic [1:0] OP_X  = 2'd0;
    localparam logic [1:0] OP_DX = 2'd1;
    localparam logic [1:0] OP_A  = 2'd2;
    localparam logic [1:0] OP_U  = 2'd3;
    localparam int DEF_OUT_W = 16;
endpackage

// File: rtl/diffeq_ctrl_timer.sv
// diffeq_ctrl_timer: loadable down-counter that stops at zero; reused for the
// strobe hold count and the WAIT timeout.
module diffeq_ctrl_timer
    import diffeq_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/diffeq_ctrl.sv
// diffeq_ctrl: loads four operands into the differentiator through s1..s4/in,
// requests a computation and returns the captured result or a timeout flag.
module diffeq_ctrl
    import diffeq_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int OUT_W          = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_x,
    input  logic [3:0]       cmd_dx,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_u,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_timeout,
    output logic             dif_s1,
    output logic             dif_s2,
    output logic             dif_s3,
    output logic             dif_s4,
    output logic [3:0]       dif_in,
    output logic             dif_ready,
    input  logic [OUT_W-1:0] dif_out,
    input  logic             dif_valid
);
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
    localparam logic [TW-1:0] HOLD_VAL = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_next;
    logic [1:0]       r_idx, w_next_idx;
    logic [3:0]       r_ops [4];
    logic [3:0]       w_next_op;
    logic             w_tload, w_ten, w_zero, w_cap, w_to;
    logic [TW-1:0]    w_tval;
    logic             r_cmd_ready, r_res_valid, r_res_timeout, r_dif_ready;
    logic [OUT_W-1:0] r_res_data;
    logic [3:0]       r_strb, r_dif_in;

    diffeq_ctrl_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_tload),
        .i_en   (w_ten),
        .i_val  (w_tval),
        .o_zero (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        w_tload    = 1'b0;
        w_ten      = 1'b0;
        w_tval     = HOLD_VAL;
        w_cap      = 1'b0;
        w_to       = 1'b0;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_next     = S_LOAD;
                w_next_idx = OP_X;
                w_tload    = 1'b1;
            end
            S_LOAD: if (w_zero) w_next = S_GAP; else w_ten = 1'b1;
            S_GAP: if (r_idx == OP_U) w_next = S_START;
            else begin
                w_next     = S_LOAD;
                w_next_idx = r_idx + 1'b1;
                w_tload    = 1'b1;
            end
            S_START: begin
                w_next  = S_WAIT;
                w_tload = 1'b1;
                w_tval  = TO_VAL;
            end
            // valid is checked first so it wins over a same-cycle timeout
            S_WAIT: if (dif_valid) begin
                w_next = S_RESP;
                w_cap  = 1'b1;
            end else if (w_zero) begin
                w_next = S_RESP;
                w_to   = 1'b1;
            end else w_ten = 1'b1;
            S_RESP: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_next_op = (r_state == S_IDLE) ? cmd_x : r_ops[w_next_idx];

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cmd_valid) begin
            r_ops[OP_X]  <= cmd_x;
            r_ops[OP_DX] <= cmd_dx;
            r_ops[OP_A]  <= cmd_a;
            r_ops[OP_U]  <= cmd_u;
        end
    end

    // outputs are decoded from the next state so every port is a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cmd_ready   <= 1'b1;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_strb        <= '0;
            r_dif_in      <= '0;
            r_dif_ready   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_next_idx;
            r_cmd_ready <= (w_next == S_IDLE);
            r_res_valid <= (w_next == S_RESP);
            r_dif_ready <= (w_next == S_START) || (w_next == S_WAIT);
            r_strb      <= (w_next == S_LOAD) ? (4'b0001 << w_next_idx) : 4'b0000;
            if (w_next == S_LOAD)
                r_dif_in <= w_next_op;
            if (w_cap || w_to) begin
                r_res_data    <= w_cap ? dif_out : '0;
                r_res_timeout <= w_to;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;
    assign {dif_s4, dif_s3, dif_s2, dif_s1} = r_strb;
    assign dif_in      = r_dif_in;
    assign dif_ready   = r_dif_ready;
endmodule

// File: tb/tb_diffeq_ctrl.sv
// tb_diffeq_ctrl: three controllers (defaults, TIMEOUT_CYCLES=8, HOLD_CYCLES=1)
// share stimulus; each has its own differentiator model answering 4 cycles after dif_ready.
module tb_diffeq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, res_ready = 1'b0, force_valid = 1'b0, model_en = 1'b1;
    logic [3:0]  cmd_x = '0, cmd_dx = '0, cmd_a = '0, cmd_u = '0;
    logic [15:0] model_data = 16'h0123;

    logic [2:0]       cmd_ready, res_valid, res_timeout, dif_ready, dif_valid;
    logic [2:0][15:0] res_data, dif_out;
    logic [2:0][3:0]  strb, dif_in;

    int checks = 0;
    int errors = 0;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        logic [7:0] mcnt;
        always @(posedge clk) mcnt <= (dif_ready[g] && !reset) ? mcnt + 8'd1 : 8'd0;
        assign dif_valid[g] = force_valid | (model_en & dif_ready[g] & (mcnt == 8'd4));
        assign dif_out[g]   = force_valid ? 16'hDEAD : model_data;
        diffeq_ctrl #(
            .HOLD_CYCLES    ((g == 2) ? 1 : 2),
            .TIMEOUT_CYCLES ((g == 1) ? 8 : 1024),
            .OUT_W          (16)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .cmd_valid   (cmd_valid),
            .cmd_ready   (cmd_ready[g]),
            .cmd_x       (cmd_x),
            .cmd_dx      (cmd_dx),
            .cmd_a       (cmd_a),
            .cmd_u       (cmd_u),
            .res_valid   (res_valid[g]),
            .res_ready   (res_ready),
            .res_data    (res_data[g]),
            .res_timeout (res_timeout[g]),
            .dif_s1      (strb[g][0]),
            .dif_s2      (strb[g][1]),
            .dif_s3      (strb[g][2]),
            .dif_s4      (strb[g][3]),
            .dif_in      (dif_in[g]),
            .dif_ready   (dif_ready[g]),
            .dif_out     (dif_out[g]),
            .dif_valid   (dif_valid[g])
        );
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        force_valid = 1'b0;
        model_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // returns at the first sample after the handshake edge
    task automatic send_cmd(input logic [3:0] x, dx, a, u);
        cmd_valid = 1'b1;
        {cmd_x, cmd_dx, cmd_a, cmd_u} = {x, dx, a, u};
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_ready[0], res_valid[0], res_timeout[0], dif_ready[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=1000", {cmd_ready[0], res_valid[0], res_timeout[0], dif_ready[0]});
        end
        checks++;
        if ({strb[0], dif_in[0], res_data[0]} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=000000", {strb[0], dif_in[0], res_data[0]});
        end
    endtask

    task automatic test_basic();
        logic [3:0] ops [4] = '{4'd3, 4'd1, 4'd7, 4'd9};
        logic [8:0] exp;
        do_reset();
        send_cmd(4'd3, 4'd1, 4'd7, 4'd9);
        for (int k = 1; k <= 13; k++) begin
            exp = {(k <= 12 && (k - 1) % 3 < 2) ? (4'b0001 << ((k - 1) / 3)) : 4'b0000,
                   ops[(k <= 12) ? (k - 1) / 3 : 3], k == 13};
            checks++;
            if ({strb[0], dif_in[0], dif_ready[0]} !== exp) begin
                errors++;
                $display("FAIL basic_seq k=%0d got=%b exp=%b", k, {strb[0], dif_in[0], dif_ready[0]}, exp);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_early got=%b exp=0", res_valid[0]);
        end
        @(negedge clk);
        checks++;
        if ({res_valid[0], res_data[0], res_timeout[0], dif_ready[0]} !== {1'b1, 16'h0123, 2'b00}) begin
            errors++;
            $display("FAIL basic_result got=%b_%h_%b_%b exp=1_0123_0_0", res_valid[0], res_data[0], res_timeout[0], dif_ready[0]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid[0], res_data[0], cmd_ready[0]} !== {1'b1, 16'h0123, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold i=%0d got=%b_%h_%b exp=1_0123_0", i, res_valid[0], res_data[0], cmd_ready[0]);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({res_valid[0], cmd_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got=%b exp=01", {res_valid[0], cmd_ready[0]});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        model_en = 1'b0;
        send_cmd(4'd5, 4'd2, 4'd8, 4'd1);
        repeat (20) @(negedge clk);
        checks++;
        if ({res_valid[1], dif_ready[1]} !== 2'b01) begin
            errors++;
            $display("FAIL to_wait got=%b exp=01", {res_valid[1], dif_ready[1]});
        end
        @(negedge clk);
        checks++;
        if ({res_valid[1], res_timeout[1], res_data[1], dif_ready[1]} !== {2'b11, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL to_result got=%b_%b_%h_%b exp=1_1_0000_0", res_valid[1], res_timeout[1], res_data[1], dif_ready[1]);
        end
        checks++;
        if ({res_valid[0], dif_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL to_long_wait got=%b exp=01", {res_valid[0], dif_ready[0]});
        end
        model_en = 1'b1;
    endtask

    task automatic test_stale_valid();
        do_reset();
        send_cmd(4'd4, 4'd5, 4'd6, 4'd7);
        @(negedge clk);
        force_valid = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            checks++;
            if ({res_valid[0], res_timeout[0]} !== 2'b00) begin
                errors++;
                $display("FAIL stale_capture k=%0d got=%b exp=00", k, {res_valid[0], res_timeout[0]});
            end
            @(negedge clk);
        end
        force_valid = 1'b0;
        checks++;
        if ({strb[0], dif_in[0]} !== {4'b0100, 4'd6}) begin
            errors++;
            $display("FAIL stale_state got=%b exp=01000110", {strb[0], dif_in[0]});
        end
        repeat (11) @(negedge clk);
        checks++;
        if ({res_valid[0], res_data[0]} !== {1'b1, 16'h0123}) begin
            errors++;
            $display("FAIL stale_result got=%b_%h exp=1_0123", res_valid[0], res_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_cmd(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (6) @(negedge clk);
        checks++;
        if ({strb[0], dif_in[0]} !== {4'b0100, 4'd3}) begin
            errors++;
            $display("FAIL mid_pre got=%b exp=01000011", {strb[0], dif_in[0]});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({strb[0], dif_ready[0], cmd_ready[0], res_valid[0]} !== 7'b0000010) begin
            errors++;
            $display("FAIL mid_abort got=%b exp=0000010", {strb[0], dif_ready[0], cmd_ready[0], res_valid[0]});
        end
        model_data = 16'hBEEF;
        send_cmd(4'd5, 4'd6, 4'd2, 4'd4);
        for (int i = 0; i < 40 && !res_valid[0]; i++) @(negedge clk);
        checks++;
        if ({res_valid[0], res_data[0], res_timeout[0]} !== {1'b1, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL mid_recover got=%b_%h_%b exp=1_beef_0", res_valid[0], res_data[0], res_timeout[0]);
        end
        model_data = 16'h0123;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
        logic [9:0] exp;
        do_reset();
        send_cmd(4'd2, 4'd4, 4'd6, 4'd8);
        cmd_valid = 1'b1;
        {cmd_x, cmd_dx, cmd_a, cmd_u} = {4'd10, 4'd11, 4'd12, 4'd13};
        for (int k = 1; k <= 9; k++) begin
            exp = {(k <= 8 && (k - 1) % 2 == 0) ? (4'b0001 << ((k - 1) / 2)) : 4'b0000,
                   ops[(k <= 8) ? (k - 1) / 2 : 3], k == 9, 1'b0};
            checks++;
            if ({strb[2], dif_in[2], dif_ready[2], cmd_ready[2]} !== exp) begin
                errors++;
                $display("FAIL b2b_seq k=%0d got=%b exp=%b", k, {strb[2], dif_in[2], dif_ready[2], cmd_ready[2]}, exp);
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({res_valid[2], res_data[2], cmd_ready[2]} !== {1'b1, 16'h0123, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first got=%b_%h_%b exp=1_0123_0", res_valid[2], res_data[2], cmd_ready[2]);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({res_valid[2], cmd_ready[2], strb[2]} !== 6'b010000) begin
            errors++;
            $display("FAIL b2b_idle got=%b exp=010000", {res_valid[2], cmd_ready[2], strb[2]});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({strb[2], dif_in[2], cmd_ready[2]} !== {4'b0001, 4'd10, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second got=%b exp=000110100", {strb[2], dif_in[2], cmd_ready[2]});
        end
        @(negedge clk);
        checks++;
        if (strb[2] !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_width got=%b exp=0000", strb[2]);
        end
        model_data = 16'h0BAD;
        for (int i = 0; i < 30 && !res_valid[2]; i++) @(negedge clk);
        checks++;
        if ({res_valid[2], res_data[2], res_timeout[2]} !== {1'b1, 16'h0BAD, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got=%b_%h_%b exp=1_0bad_0", res_valid[2], res_data[2], res_timeout[2]);
        end
        model_data = 16'h0123;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_stale_valid();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/diffeq_ctrl.md
Name: diffeq_ctrl

Overview:
Sequencer that drives the `differentiator` datapath's load/start protocol on behalf of a single upstream requester.
- Accepts one packed operand command (x, dx, a, u) over a valid/ready handshake.
- Loads the four operands through strobes s1..s4 and the shared 4-bit `in` bus, then raises `ready`.
- Waits for `valid`, captures `out`, and returns the result (or a timeout flag) over a valid/ready handshake.

Parameters:
- HOLD_CYCLES, 2: cycles each load strobe is held high. Legal range is 1..15.
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before the operation is aborted. Must be ≥2.
- OUT_W, 16: width of the differentiator result.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  block idle, command accepted when cmd_valid&&cmd_ready
- cmd_x, cmd_dx, cmd_a, cmd_u  in  4 each  operands
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_data  out  OUT_W  captured differentiator output (0 on timeout)
- res_timeout  out  1  operation aborted by timeout
- dif_s1, dif_s2, dif_s3, dif_s4  out  1 each  load strobes to the differentiator
- dif_in  out  4  operand bus to the differentiator
- dif_ready  out  1  start/compute request to the differentiator
- dif_out  in  OUT_W  differentiator result
- dif_valid  in  1  differentiator result valid

Behaviour:
- Reset: state IDLE. Outputs cmd_ready=1, res_valid=0, res_data=0, res_timeout=0, dif_s1..s4=0, dif_in=0, dif_ready=0. Internal counters cleared. Reset asserted mid-operation aborts immediately: strobes and dif_ready drop the next cycle, and no result is produced.
- States: IDLE, LOAD (operand index 0..3), GAP, START, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake: operands register and cmd_ready=0 from the next cycle; go to LOAD, index 0.
- LOAD:
  - dif_in = operand[index] (0=x, 1=dx, 2=a, 3=u).
  - Exactly one strobe is high (s1..s4 for index 0..3), for HOLD_CYCLES cycles.
  - Then go to GAP.
- GAP:
  - One cycle with all strobes low; dif_in keeps the last operand.
  - Index<3: index+1, go to LOAD. Index=3: go to START.
  - Strobes never overlap, and dif_in only changes while all strobes are low.
- START:
  - dif_ready=1. Clear the timeout counter; go to WAIT.
- WAIT:
  - dif_ready stays 1.
  - dif_valid is sampled only in WAIT. dif_valid in any other state is ignored, so a stale valid is never captured.
  - dif_valid=1: res_data<=dif_out, res_timeout<=0, go to RESP.
  - Otherwise counter+1. When counter reaches TIMEOUT_CYCLES-1 without valid: res_data<=0, res_timeout<=1, go to RESP.
  - If valid and timeout occur in the same cycle, valid wins.
- RESP:
  - dif_ready=0, res_valid=1. res_data and res_timeout stay stable until the handshake.
  - On res_valid&&res_ready: res_valid=0 next cycle, go to IDLE.
  - cmd_ready returns to 1 only in IDLE. A command and a response cannot complete in the same cycle.
- Latency:
  - Handshake at edge E → dif_s1 high from E+1.
  - Load phase = 4*(HOLD_CYCLES+1) cycles. With defaults dif_ready rises at E+13.
  - Result captured on the edge that samples dif_valid; res_valid is high the following cycle.
- Timing rules: all outputs are registered, and there is no combinational path from dif_valid to res_valid.

Decomposition:
- Package diffeq_ctrl_pkg holds:
  - the state enum;
  - operand index constants OP_X=0, OP_DX=1, OP_A=2, OP_U=3;
  - OUT_W default.
- One sub-module, diffeq_ctrl_timer: a shared down-counter with load/enable/zero. It serves both the HOLD count and the WAIT timeout.

Test Plan:
1. Basic load sequence, defaults: cmd x=3, dx=1, a=7, u=9; behavioural DUT model returns 16'h0123 four cycles after dif_ready.
   - Required strobe timing: s1 with in=3 at E+1..E+2, s2 with in=1 at E+4..5, s3 with in=7 at E+7..8, s4 with in=9 at E+10..11.
   - Required result: dif_ready at E+13; res_valid=1, res_data=16'h0123, res_timeout=0.
2. Response backpressure: res_ready held 0 for 10 cycles.
   - res_data stable throughout; cmd_ready stays 0.
   - Release res_ready → IDLE and cmd_ready=1 the next cycle.
3. Timeout: TIMEOUT_CYCLES=8 and the model never asserts valid.
   - res_timeout=1 and res_data=0 after 8 WAIT cycles; dif_ready drops.
4. Stale valid: dif_valid forced high during LOAD.
   - Ignored: no capture and no state change. The first capture happens in WAIT only.
5. Reset mid-operation: reset asserted while in the s3 LOAD phase.
   - Next cycle: all strobes 0, dif_ready=0, cmd_ready=1, res_valid=0.
   - A new command afterwards completes normally.
6. Short hold: HOLD_CYCLES=1 with back-to-back commands.
   - Each strobe is high for exactly 1 cycle; dif_ready rises at E+9.
   - Second command accepted only after the first response handshake.
